exe_stage_mc: RTL and testbench
===============================

Name: exe_stage_mc

Overview:
Parametrised multi-cycle execute stage for the pipelined MIPS core.
- Forwards three operands from the MEM and WB stages.
- Computes one of three results: ALU result, barrel shift (logical or arithmetic, immediate or variable amount), or iterative multiply/divide.
- Registers the result into an internal EXE/MEM output register with a valid/ready handshake, so multi-cycle ops stall the front end.

Parameters:
- WORD_LEN, 32, datapath width (power of 2, >= 8).
- EXE_CMD_LEN, 4, ALU command width.
- SHAMT_LEN, $clog2(WORD_LEN), localparam, shift-amount width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID/EX holds a valid instruction
- in_ready  out  1  stage accepts the instruction this cycle
- exe_cmd  in  EXE_CMD_LEN  ALU operation
- result_sel  in  2  00 ALU, 01 shifter, 10 muldiv, 11 reserved (result 0)
- shift_dir  in  1  0 left, 1 right
- shift_arith  in  1  right shift sign-fills
- shamt_var  in  1  1: amount = op1[SHAMT_LEN-1:0]; 0: amount = shamt
- shamt  in  SHAMT_LEN  immediate shift amount
- md_op  in  2  00 MUL, 01 MULU, 10 DIV, 11 DIVU
- md_hi  in  1  return HI (mul upper half / remainder) instead of LO
- alu_src1_sel, alu_src2_sel, store_value_sel  in  2 each  00 ID/EX value, 01 alu_result_mem, 10 result_wb, 11 ID/EX value
- alu_input1, alu_input2, store_value_in  in  WORD_LEN  ID/EX operands
- alu_result_mem, result_wb  in  WORD_LEN  forwarding sources
- out_valid  out  1  output register holds a result
- out_ready  in  1  MEM stage consumes the result
- alu_result, store_value  out  WORD_LEN  registered results

Behaviour:
- Reset, asynchronous: out_valid=0, alu_result=0, store_value=0, FSM=IDLE, iteration counter=0, accumulators=0.
- Operands: op1 and op2 come from the forwarding muxes, which are combinational. The shifter uses the forwarded op2. Forward selects are meaningful only in the accept cycle.
- Accept condition: in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Single-cycle ops (result_sel 00/01/11): on accept, alu_result and store_value load at the next edge and out_valid=1. Latency is 1 cycle; sustained throughput is 1 per cycle.
- Output hold: if out_valid && !out_ready, the output register and out_valid are held and in_ready=0.
- Consume without refill: out_valid clears when out_ready=1 and no new result loads the same cycle.
- Shifter, left: zero-fill. Right: sign-fills when shift_arith=1, otherwise zero-fill. Amount 0 passes op2 unchanged.
- Muldiv FSM, IDLE -> BUSY:
  - On accept with result_sel=10, latch op1, op2, md_op, md_hi and the forwarded store value.
  - Signed ops convert operands to magnitudes and record the result signs.
- BUSY: one radix-2 step per cycle for WORD_LEN cycles; counter runs 0..WORD_LEN-1. in_ready=0.
- BUSY -> DONE: when the counter reaches WORD_LEN-1.
- DONE:
  - Apply sign correction and select HI or LO.
  - Load the output register when !out_valid || out_ready; otherwise wait in DONE.
  - Then return to IDLE.
  - Total accept-to-out_valid latency is WORD_LEN+2 cycles.
- Divide by zero: quotient = all ones (DIVU) or -1 (DIV); remainder = dividend. Result still ready after full latency.
- Signed overflow, DIV with MIN / -1: quotient = MIN, remainder = 0.
- MUL sign rule: signed product is the 2*WORD_LEN-bit two's complement. Remainder takes the sign of the dividend.
- Reset mid-operation: aborts to IDLE; partial results are discarded.

Optional Feature:
- Macro: EXE_MULDIV_EN.
- Defined: muldiv FSM and datapath as above.
- Undefined: no FSM, counter or accumulators. result_sel=10 behaves as a single-cycle op with result 0. in_ready = !out_valid || out_ready.

Decomposition:
- Shared defines package, alongside the existing defines.v:
  - WORD_LEN default.
  - EXE_CMD codes.
  - result_sel codes (RES_ALU, RES_SHIFT, RES_MD).
  - md_op codes.
  - forward-select codes.
  - FSM state encoding (S_IDLE, S_BUSY, S_DONE).
- The existing ALU and 3-input mux are reused.
- One natural sub-module: muldiv_iter, holding the FSM, counter, and shift-add / restoring-divide datapath with a start/done interface.

Test Plan:
- Forwarding: alu_input1=5, alu_result_mem=7, result_wb=9, src1_sel=01, src2_sel=10, ADD -> alu_result=16 one cycle after accept.
- Shifter: op2=0x80000000, right, shift_arith=1, shamt=4 -> 0xF8000000; with shift_arith=0 -> 0x08000000. shamt_var=1, op1=33 -> shift by 1.
- Back-pressure: single-cycle ADD, out_ready=0 for 3 cycles -> out_valid and alu_result held, in_ready=0; on out_ready=1, next accept occurs the same cycle.
- Signed multiply: MUL -3 x 7 -> LO=0xFFFFFFEB, HI=0xFFFFFFFF, out_valid exactly 34 cycles after accept, in_ready=0 throughout.
- Divide corner cases:
  - DIV -7/2 -> LO=-3, HI=-1.
  - DIVU 10/0 -> LO=0xFFFFFFFF, HI=10.
  - DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- Reset: assert rst_n=0 at BUSY cycle 10 -> out_valid=0 and in_ready=1 right after release; the next ADD completes normally.

Source files
------------

// File: rtl/exe_stage_mc_pkg.sv
// Shared encodings for the execute stage: ALU commands, result and md_op selects,
// forward selects and muldiv FSM states. Pure declarations, no logic.
// Consumers import this package; widths here match the default build (4-bit EXE_CMD).
package exe_stage_mc_pkg;

  localparam int WORD_LEN_DEF = 32;

  // ALU commands
  localparam logic [3:0] EXE_ADD = 4'b0000;
  localparam logic [3:0] EXE_SUB = 4'b0010;
  localparam logic [3:0] EXE_AND = 4'b0100;
  localparam logic [3:0] EXE_OR  = 4'b0101;
  localparam logic [3:0] EXE_NOR = 4'b0110;
  localparam logic [3:0] EXE_XOR = 4'b0111;
  localparam logic [3:0] EXE_SLT = 4'b1011;
  localparam logic [3:0] EXE_NOP = 4'b1111;

  // Result source
  localparam logic [1:0] RES_ALU   = 2'b00;
  localparam logic [1:0] RES_SHIFT = 2'b01;
  localparam logic [1:0] RES_MD    = 2'b10;
  localparam logic [1:0] RES_NONE  = 2'b11;

  // Multiply/divide operation
  localparam logic [1:0] MD_MUL  = 2'b00;
  localparam logic [1:0] MD_MULU = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;
  localparam logic [1:0] MD_DIVU = 2'b11;

  // Forwarding source
  localparam logic [1:0] FWD_IDEX = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } md_state_t;

endpackage

// File: rtl/exe_stage_mc_muldiv_iter.sv
// Iterative radix-2 multiply (shift-add) / divide (restoring), signed and unsigned.
// Latency: start edge, WORD_LEN step edges, then one DONE edge that hands off the result.
// Backpressure: waits in DONE until take=1; idle=0 from start until the hand-off edge.
// Only present when EXE_MULDIV_EN is defined.
`ifdef EXE_MULDIV_EN
module muldiv_iter
  import exe_stage_mc_pkg::*;
#(
  parameter int WORD_LEN = WORD_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WORD_LEN-1:0] a,
  input  logic [WORD_LEN-1:0] b,
  input  logic [1:0]          md_op,
  input  logic                md_hi,
  input  logic                take,
  output logic                idle,
  output logic                done,
  output logic [WORD_LEN-1:0] result
);

  localparam int CNT_W = $clog2(WORD_LEN);

  md_state_t            state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [WORD_LEN-1:0]  acc_hi, acc_lo, dsr;
  logic                 is_div, want_hi, res_neg, rem_neg, b_zero;

  logic                 signed_in, a_neg_in, b_neg_in;
  logic [WORD_LEN-1:0]  a_mag, b_mag;
  logic [WORD_LEN:0]    mul_sum, div_sh;
  logic [WORD_LEN-1:0]  div_diff;
  logic                 div_ge;
  logic [2*WORD_LEN-1:0] prod, prod_fix;
  logic [WORD_LEN-1:0]  quo, rem;

  // Operand magnitudes and signs captured at start
  always_comb begin
    signed_in = (md_op == MD_MUL) || (md_op == MD_DIV);
    a_neg_in  = signed_in && a[WORD_LEN-1];
    b_neg_in  = signed_in && b[WORD_LEN-1];
    a_mag     = a_neg_in ? -a : a;
    b_mag     = b_neg_in ? -b : b;
  end

  // One radix-2 step for each algorithm
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dsr} : '0);
    div_sh   = {acc_hi, acc_lo[WORD_LEN-1]};
    div_ge   = div_sh >= {1'b0, dsr};
    div_diff = div_sh[WORD_LEN-1:0] - dsr;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_BUSY;
      S_BUSY:  if (cnt == CNT_W'(WORD_LEN - 1)) state_nxt = S_DONE;
      S_DONE:  if (take) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: handshake flags and sign-corrected HI/LO selection
  always_comb begin
    idle     = (state == S_IDLE);
    done     = (state == S_DONE) && take;
    prod     = {acc_hi, acc_lo};
    prod_fix = res_neg ? -prod : prod;
    // Zero divisor: every trial subtract succeeds, so the magnitude quotient is all
    // ones; force all ones regardless of sign so DIV reports -1 too.
    quo      = b_zero ? '1 : (res_neg ? -acc_lo : acc_lo);
    rem      = rem_neg ? -acc_hi : acc_hi;
    if (is_div) result = want_hi ? rem : quo;
    else        result = want_hi ? prod_fix[2*WORD_LEN-1:WORD_LEN] : prod_fix[WORD_LEN-1:0];
  end

  // Datapath: latch operands on start, iterate while BUSY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      dsr     <= '0;
      is_div  <= 1'b0;
      want_hi <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      b_zero  <= 1'b0;
    end else if (state == S_IDLE && start) begin
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= a_mag;
      dsr     <= b_mag;
      is_div  <= md_op[1];
      want_hi <= md_hi;
      res_neg <= a_neg_in ^ b_neg_in;
      rem_neg <= a_neg_in;
      b_zero  <= (b == '0);
    end else if (state == S_BUSY) begin
      cnt <= cnt + 1'b1;
      if (is_div) begin
        acc_hi <= div_ge ? div_diff : div_sh[WORD_LEN-1:0];
        acc_lo <= {acc_lo[WORD_LEN-2:0], div_ge};
      end else begin
        acc_hi <= mul_sum[WORD_LEN:1];
        acc_lo <= {mul_sum[0], acc_lo[WORD_LEN-1:1]};
      end
    end
  end

endmodule
`endif

// File: rtl/exe_stage_mc.sv
// MIPS execute stage: operand forwarding, ALU, barrel shifter, optional iterative muldiv.
// Latency: 1 cycle for ALU/shift/reserved; WORD_LEN+2 cycles for muldiv (EXE_MULDIV_EN).
// Backpressure: output register holds while out_valid && !out_ready; in_ready drops then
// and for the whole muldiv operation.
module exe_stage_mc
  import exe_stage_mc_pkg::*;
#(
  parameter  int WORD_LEN    = WORD_LEN_DEF,
  parameter  int EXE_CMD_LEN = 4,
  localparam int SHAMT_LEN   = $clog2(WORD_LEN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXE_CMD_LEN-1:0] exe_cmd,
  input  logic [1:0]             result_sel,
  input  logic                   shift_dir,
  input  logic                   shift_arith,
  input  logic                   shamt_var,
  input  logic [SHAMT_LEN-1:0]   shamt,
  input  logic [1:0]             md_op,
  input  logic                   md_hi,
  input  logic [1:0]             alu_src1_sel,
  input  logic [1:0]             alu_src2_sel,
  input  logic [1:0]             store_value_sel,
  input  logic [WORD_LEN-1:0]    alu_input1,
  input  logic [WORD_LEN-1:0]    alu_input2,
  input  logic [WORD_LEN-1:0]    store_value_in,
  input  logic [WORD_LEN-1:0]    alu_result_mem,
  input  logic [WORD_LEN-1:0]    result_wb,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_LEN-1:0]    alu_result,
  output logic [WORD_LEN-1:0]    store_value
);

  function automatic logic [WORD_LEN-1:0] fwd_mux(input logic [1:0] sel,
                                                  input logic [WORD_LEN-1:0] idex,
                                                  input logic [WORD_LEN-1:0] mem,
                                                  input logic [WORD_LEN-1:0] wb);
    case (sel)
      FWD_MEM: fwd_mux = mem;
      FWD_WB:  fwd_mux = wb;
      default: fwd_mux = idex;
    endcase
  endfunction

  logic [WORD_LEN-1:0]  op1, op2, st_fwd, alu_out, shift_out, single_res;
  logic [SHAMT_LEN-1:0] shift_amt;
  logic                 accept, out_take, load_single;
  logic                 md_done;
  logic [WORD_LEN-1:0]  md_result, md_store;

  // Forwarding muxes, then ALU
  always_comb begin
    op1     = fwd_mux(alu_src1_sel, alu_input1, alu_result_mem, result_wb);
    op2     = fwd_mux(alu_src2_sel, alu_input2, alu_result_mem, result_wb);
    st_fwd  = fwd_mux(store_value_sel, store_value_in, alu_result_mem, result_wb);
    alu_out = '0;
    case (exe_cmd)
      EXE_ADD: alu_out = op1 + op2;
      EXE_SUB: alu_out = op1 - op2;
      EXE_AND: alu_out = op1 & op2;
      EXE_OR:  alu_out = op1 | op2;
      EXE_NOR: alu_out = ~(op1 | op2);
      EXE_XOR: alu_out = op1 ^ op2;
      EXE_SLT: alu_out = {{(WORD_LEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      default: alu_out = '0;
    endcase
  end

  // Barrel shifter on forwarded op2; variable amount comes from op1's low bits
  always_comb begin
    shift_amt = shamt_var ? op1[SHAMT_LEN-1:0] : shamt;
    if (!shift_dir)       shift_out = op2 << shift_amt;
    else if (shift_arith) shift_out = $signed(op2) >>> shift_amt;
    else                  shift_out = op2 >> shift_amt;
    case (result_sel)
      RES_ALU:   single_res = alu_out;
      RES_SHIFT: single_res = shift_out;
      default:   single_res = '0;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign out_take = !out_valid || out_ready;

`ifdef EXE_MULDIV_EN
  logic md_idle;

  muldiv_iter #(.WORD_LEN(WORD_LEN)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && (result_sel == RES_MD)),
    .a      (op1),
    .b      (op2),
    .md_op  (md_op),
    .md_hi  (md_hi),
    .take   (out_take),
    .idle   (md_idle),
    .done   (md_done),
    .result (md_result)
  );

  // Store value travels alongside the muldiv op, captured at accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              md_store <= '0;
    else if (accept && result_sel == RES_MD) md_store <= st_fwd;
  end

  assign in_ready    = md_idle && out_take;
  assign load_single = accept && (result_sel != RES_MD);
`else
  logic unused_md;
  assign unused_md   = ^{md_op, md_hi};
  assign md_done     = 1'b0;
  assign md_result   = '0;
  assign md_store    = '0;
  assign in_ready    = out_take;
  assign load_single = accept;
`endif

  // EXE/MEM output register: load single-cycle or muldiv result, clear on consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      alu_result  <= '0;
      store_value <= '0;
    end else if (load_single) begin
      out_valid   <= 1'b1;
      alu_result  <= single_res;
      store_value <= st_fwd;
    end else if (md_done) begin
      out_valid   <= 1'b1;
      alu_result  <= md_result;
      store_value <= md_store;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed bench for exe_stage_mc: vector table for single-cycle ops, hand sequences
// for back-pressure, reset and (when EXE_MULDIV_EN is defined) multiply/divide.
// Outputs are sampled 1 time unit after the rising edge.
module tb_exe_stage_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  exe_cmd;
  logic [1:0]  result_sel, md_op;
  logic        shift_dir, shift_arith, shamt_var, md_hi;
  logic [4:0]  shamt;
  logic [1:0]  alu_src1_sel, alu_src2_sel, store_value_sel;
  logic [31:0] alu_input1, alu_input2, store_value_in, alu_result_mem, result_wb;
  logic [31:0] alu_result, store_value;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_stage_mc dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .exe_cmd(exe_cmd), .result_sel(result_sel), .shift_dir(shift_dir),
    .shift_arith(shift_arith), .shamt_var(shamt_var), .shamt(shamt),
    .md_op(md_op), .md_hi(md_hi), .alu_src1_sel(alu_src1_sel),
    .alu_src2_sel(alu_src2_sel), .store_value_sel(store_value_sel),
    .alu_input1(alu_input1), .alu_input2(alu_input2), .store_value_in(store_value_in),
    .alu_result_mem(alu_result_mem), .result_wb(result_wb),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .store_value(store_value)
  );

  typedef struct {
    string       name;
    logic [3:0]  cmd;
    logic [1:0]  rsel;
    logic        sdir, sarith, svar;
    logic [4:0]  shamt;
    logic [1:0]  s1, s2, ss;
    logic [31:0] a1, a2, st, mem, wb;
    logic [31:0] exp_res, exp_st;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [3:0] cmd, input logic [1:0] rsel,
                              input logic sdir, input logic sarith, input logic svar,
                              input logic [4:0] sh, input logic [1:0] s1, input logic [1:0] s2,
                              input logic [1:0] ss, input logic [31:0] a1, input logic [31:0] a2,
                              input logic [31:0] st, input logic [31:0] mem, input logic [31:0] wb,
                              input logic [31:0] er, input logic [31:0] es);
    vec_t v;
    v.name = name; v.cmd = cmd; v.rsel = rsel; v.sdir = sdir; v.sarith = sarith;
    v.svar = svar; v.shamt = sh; v.s1 = s1; v.s2 = s2; v.ss = ss; v.a1 = a1; v.a2 = a2;
    v.st = st; v.mem = mem; v.wb = wb; v.exp_res = er; v.exp_st = es;
    return v;
  endfunction

  task automatic drive_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    exe_cmd = cmd; result_sel = 2'b00; alu_src1_sel = 2'b00; alu_src2_sel = 2'b00;
    store_value_sel = 2'b00; alu_input1 = a; alu_input2 = b; store_value_in = 32'h0;
    in_valid = 1'b1;
  endtask

`ifdef EXE_MULDIV_EN
  task automatic run_md(input string name, input logic [1:0] op, input logic hi,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                        input logic [31:0] st);
    int cnt;
    logic busy_ok;
    result_sel = 2'b10; md_op = op; md_hi = hi;
    alu_src1_sel = 2'b00; alu_src2_sel = 2'b00; store_value_sel = 2'b00;
    alu_input1 = a; alu_input2 = b; store_value_in = st; out_ready = 1'b1; in_valid = 1'b1;
    #1;
    chk({name, " in_ready_idle"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; alu_input1 = 32'hFFFF_FFFF; alu_input2 = 32'h0; store_value_in = 32'h0;
    cnt = 1;
    busy_ok = 1'b1;
    while (!out_valid && cnt < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      cnt++;
    end
    chk({name, " latency"}, cnt, 32'd34);
    chk({name, " in_ready_busy"}, {31'b0, busy_ok}, 32'd1);
    chk({name, " result"}, alu_result, exp);
    chk({name, " store"}, store_value, st);
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    exe_cmd = 4'b0000; result_sel = 2'b00; shift_dir = 1'b0; shift_arith = 1'b0;
    shamt_var = 1'b0; shamt = 5'd0; md_op = 2'b00; md_hi = 1'b0;
    alu_src1_sel = 2'b00; alu_src2_sel = 2'b00; store_value_sel = 2'b00;
    alu_input1 = 32'h0; alu_input2 = 32'h0; store_value_in = 32'h0;
    alu_result_mem = 32'h0; result_wb = 32'h0;

    //        name          cmd      rsel   dir ar var sh   s1     s2     ss     a1            a2            st           mem          wb           exp_res       exp_st
    vecs.push_back(mk("fwd_add",  4'b0000, 2'b00, 0, 0, 0, 5'd0, 2'b01, 2'b10, 2'b00, 32'd5,        32'd0,        32'h1234,    32'd7,       32'd9,       32'd16,       32'h1234));
    vecs.push_back(mk("sub_st_mem", 4'b0010, 2'b00, 0, 0, 0, 5'd0, 2'b00, 2'b00, 2'b01, 32'd100,    32'd30,       32'h0,       32'd7,       32'd9,       32'd70,       32'd7));
    vecs.push_back(mk("and_st_wb", 4'b0100, 2'b00, 0, 0, 0, 5'd0, 2'b00, 2'b00, 2'b10, 32'hF0F0,    32'hFF00,     32'h0,       32'd7,       32'hABCD,    32'hF000,     32'hABCD));
    vecs.push_back(mk("or_sel11", 4'b0101, 2'b00, 0, 0, 0, 5'd0, 2'b11, 2'b11, 2'b11, 32'h0F,       32'hF0,       32'h77,      32'd7,       32'd9,       32'hFF,       32'h77));
    vecs.push_back(mk("xor",      4'b0111, 2'b00, 0, 0, 0, 5'd0, 2'b00, 2'b00, 2'b00, 32'hFF,       32'h0F,       32'h1,       32'd7,       32'd9,       32'hF0,       32'h1));
    vecs.push_back(mk("nor",      4'b0110, 2'b00, 0, 0, 0, 5'd0, 2'b00, 2'b00, 2'b00, 32'h0,        32'h0,        32'h2,       32'd7,       32'd9,       32'hFFFF_FFFF, 32'h2));
    vecs.push_back(mk("slt_neg",  4'b1011, 2'b00, 0, 0, 0, 5'd0, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd1,       32'h3,       32'd7,       32'd9,       32'd1,        32'h3));
    vecs.push_back(mk("sra4",     4'b0000, 2'b01, 1, 1, 0, 5'd4, 2'b00, 2'b00, 2'b00, 32'h0,        32'h8000_0000, 32'h4,      32'd7,       32'd9,       32'hF800_0000, 32'h4));
    vecs.push_back(mk("srl4",     4'b0000, 2'b01, 1, 0, 0, 5'd4, 2'b00, 2'b00, 2'b00, 32'h0,        32'h8000_0000, 32'h5,      32'd7,       32'd9,       32'h0800_0000, 32'h5));
    vecs.push_back(mk("sll_var33", 4'b0000, 2'b01, 0, 0, 1, 5'd9, 2'b00, 2'b00, 2'b00, 32'd33,      32'd3,        32'h6,       32'd7,       32'd9,       32'd6,        32'h6));
    vecs.push_back(mk("srl_var33", 4'b0000, 2'b01, 1, 0, 1, 5'd9, 2'b00, 2'b00, 2'b00, 32'd33,      32'h8000_0000, 32'h7,      32'd7,       32'd9,       32'h4000_0000, 32'h7));
    vecs.push_back(mk("sra0_pass", 4'b0000, 2'b01, 1, 1, 0, 5'd0, 2'b00, 2'b00, 2'b00, 32'h0,       32'hDEAD_BEEF, 32'h8,      32'd7,       32'd9,       32'hDEAD_BEEF, 32'h8));
    vecs.push_back(mk("sll31",    4'b0000, 2'b01, 0, 0, 0, 5'd31, 2'b00, 2'b00, 2'b00, 32'h0,       32'd1,        32'h9,       32'd7,       32'd9,       32'h8000_0000, 32'h9));
    vecs.push_back(mk("sll_fwd_mem", 4'b0000, 2'b01, 0, 0, 0, 5'd4, 2'b00, 2'b01, 2'b00, 32'h0,     32'h0,        32'hA,       32'h10,      32'd9,       32'h100,      32'hA));
    vecs.push_back(mk("reserved", 4'b0000, 2'b11, 0, 0, 0, 5'd0, 2'b00, 2'b00, 2'b00, 32'd5,        32'd6,        32'h55,      32'd7,       32'd9,       32'h0,        32'h55));
`ifndef EXE_MULDIV_EN
    vecs.push_back(mk("md_disabled", 4'b0000, 2'b10, 0, 0, 0, 5'd0, 2'b00, 2'b00, 2'b00, 32'd3,     32'd7,        32'h66,      32'd7,       32'd9,       32'h0,        32'h66));
`endif

    // Reset state
    @(posedge clk); #1;
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst alu_result", alu_result, 32'd0);
    chk("rst store_value", store_value, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);

    // Single-cycle table, one accept per cycle
    foreach (vecs[i]) begin
      exe_cmd = vecs[i].cmd; result_sel = vecs[i].rsel; shift_dir = vecs[i].sdir;
      shift_arith = vecs[i].sarith; shamt_var = vecs[i].svar; shamt = vecs[i].shamt;
      alu_src1_sel = vecs[i].s1; alu_src2_sel = vecs[i].s2; store_value_sel = vecs[i].ss;
      alu_input1 = vecs[i].a1; alu_input2 = vecs[i].a2; store_value_in = vecs[i].st;
      alu_result_mem = vecs[i].mem; result_wb = vecs[i].wb; in_valid = 1'b1;
      @(posedge clk); #1;
      chk({vecs[i].name, " out_valid"}, {31'b0, out_valid}, 32'd1);
      chk({vecs[i].name, " result"}, alu_result, vecs[i].exp_res);
      chk({vecs[i].name, " store"}, store_value, vecs[i].exp_st);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("consume clears out_valid", {31'b0, out_valid}, 32'd0);

    // Back-pressure: hold for 3 cycles, then accept the same cycle out_ready rises
    shift_dir = 1'b0; shift_arith = 1'b0; shamt_var = 1'b0; shamt = 5'd0;
    drive_alu(4'b0000, 32'd1, 32'd2);
    out_ready = 1'b0;
    @(posedge clk); #1;
    drive_alu(4'b0000, 32'd10, 32'd20);
    for (int k = 0; k < 3; k++) begin
      chk("bp in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      chk("bp out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp hold result", alu_result, 32'd3);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("bp next result", alu_result, 32'd30);
    chk("bp next valid", {31'b0, out_valid}, 32'd1);

    // Reset while a result is held
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst alu_result", alu_result, 32'd0);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;

`ifdef EXE_MULDIV_EN
    run_md("mul_lo",     2'b00, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'h1111);
    run_md("mul_hi",     2'b00, 1'b1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'h2222);
    run_md("mulu_hi",    2'b01, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'h3333);
    run_md("div_lo",     2'b10, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'h4444);
    run_md("div_hi",     2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'h5555);
    run_md("divu0_lo",   2'b11, 1'b0, 32'd10, 32'd0, 32'hFFFF_FFFF, 32'h6666);
    run_md("divu0_hi",   2'b11, 1'b1, 32'd10, 32'd0, 32'd10, 32'h7777);
    run_md("div0_hi",    2'b10, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'h8888);
    run_md("divovf_lo",  2'b10, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h9999);
    run_md("divovf_hi",  2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'hAAAA);

    // Reset in the middle of a multiply
    result_sel = 2'b10; md_op = 2'b00; md_hi = 1'b0;
    alu_input1 = 32'd3; alu_input2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("mid busy in_ready", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    chk("mid rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid rst in_ready", {31'b0, in_ready}, 32'd1);
    begin
      logic stale;
      stale = 1'b0;
      repeat (40) begin
        @(posedge clk); #1;
        if (out_valid) stale = 1'b1;
      end
      chk("mid rst no stale result", {31'b0, stale}, 32'd0);
    end
`endif

    // Normal ADD after the reset
    drive_alu(4'b0000, 32'd2, 32'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post rst add valid", {31'b0, out_valid}, 32'd1);
    chk("post rst add result", alu_result, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
